// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer
//   Drives a character LCD in 4-bit mode. After reset it waits for the panel's
//   power-up time, sends the four-nibble init sequence (3,3,3,2), then accepts
//   byte writes (command or character data) over a valid/ready handshake.
//   Each byte is sent as a high nibble and then a low nibble. Every nibble is
//   strobed in three phases: setup (e=0), pulse (e=1) and hold (e=0). After
//   the second nibble the block waits for the LCD to finish the command.
//
//   Handshake: a byte transfers on the rising clock edge where
//   req_valid & req_ready are both 1. req_ready is 1 only in IDLE. The
//   requester keeps req_valid, req_rs and req_data stable until that edge.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   req_valid/ready  byte write handshake
//   req_rs           0 = command, 1 = character data
//   req_data         byte to write
//   init_done        1 once the power-on init has finished (until reset)
//   sf_e             StrataFlash disable, tied to 1
//   e, rs, rw        LCD enable strobe, register select, read/write (tied 0)
//   d, c, b, a       LCD data nibble, bit 3 down to bit 0
//   dbg_state        current FSM state, for observation only
module lcd_write_sequencer #(
  parameter int T_PWRUP  = 750000,
  parameter int T_INIT1  = 205000,
  parameter int T_INIT2  = 5000,
  parameter int T_SETUP  = 2,
  parameter int T_EPULSE = 12,
  parameter int T_HOLD   = 1,
  parameter int T_GAP    = 50,
  parameter int T_CMD    = 2000,
  parameter int T_CLEAR  = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       sf_e,
  output logic       e,
  output logic       rs,
  output logic       rw,
  output logic       d,
  output logic       c,
  output logic       b,
  output logic       a,
  output logic [2:0] dbg_state
);

  function automatic int max_of(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  localparam int T_MAX = max_of(max_of(max_of(T_PWRUP, T_INIT1), max_of(T_INIT2, T_SETUP)),
                                max_of(max_of(T_EPULSE, T_HOLD), max_of(max_of(T_GAP, T_CMD), T_CLEAR)));
  localparam int CW = $clog2(T_MAX + 1);

  // A state that must last N clocks is entered with the counter at N-1 and
  // left on the clock where the counter reads zero.
  localparam logic [CW-1:0] L_PWRUP  = CW'(T_PWRUP - 2);
  localparam logic [CW-1:0] L_INIT1  = CW'(T_INIT1 - 1);
  localparam logic [CW-1:0] L_INIT2  = CW'(T_INIT2 - 1);
  localparam logic [CW-1:0] L_SETUP  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] L_EPULSE = CW'(T_EPULSE - 1);
  localparam logic [CW-1:0] L_HOLD   = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] L_GAP    = CW'(T_GAP - 1);
  localparam logic [CW-1:0] L_CMD    = CW'(T_CMD - 1);
  localparam logic [CW-1:0] L_CLEAR  = CW'(T_CLEAR - 1);

  typedef enum logic [2:0] {
    S_PWR_WAIT  = 3'd0,
    S_NIB_SETUP = 3'd1,
    S_NIB_HIGH  = 3'd2,
    S_NIB_HOLD  = 3'd3,
    S_INIT_WAIT = 3'd4,
    S_IDLE      = 3'd5,
    S_GAP       = 3'd6,
    S_BUSY      = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;      // power-up wait has loaded the counter
  logic [1:0]    step_q, step_d;        // index of the init nibble in flight
  logic          low_q, low_d;          // the low nibble of a byte is in flight
  logic          clr_q, clr_d;          // current byte needs the long busy wait
  logic [3:0]    lo_q, lo_d;            // low nibble waiting to be sent
  logic          init_done_q, init_done_d;
  logic          e_q, e_d;
  logic          rs_q, rs_d;
  logic [3:0]    nib_q, nib_d;
  logic          cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PWR_WAIT;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      step_q      <= 2'd0;
      low_q       <= 1'b0;
      clr_q       <= 1'b0;
      lo_q        <= 4'h0;
      init_done_q <= 1'b0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      nib_q       <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      step_q      <= step_d;
      low_q       <= low_d;
      clr_q       <= clr_d;
      lo_q        <= lo_d;
      init_done_q <= init_done_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      nib_q       <= nib_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_zero ? cnt_q : cnt_q - CW'(1);
    armed_d     = armed_q;
    step_d      = step_q;
    low_d       = low_q;
    clr_d       = clr_q;
    lo_d        = lo_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    nib_d       = nib_q;

    unique case (state_q)
      S_PWR_WAIT: begin
        // The counter comes out of reset cleared, so the first cycle of the
        // power-up wait loads it and the remaining T_PWRUP-1 cycles count down.
        if (!armed_q) begin
          armed_d = 1'b1;
          cnt_d   = L_PWRUP;
        end else if (cnt_zero) begin
          state_d = S_NIB_SETUP;
          cnt_d   = L_SETUP;
          step_d  = 2'd0;
          rs_d    = 1'b0;
          nib_d   = 4'h3;
        end
      end
      S_NIB_SETUP: begin
        if (cnt_zero) begin
          state_d = S_NIB_HIGH;
          cnt_d   = L_EPULSE;
        end
      end
      S_NIB_HIGH: begin
        if (cnt_zero) begin
          state_d = S_NIB_HOLD;
          cnt_d   = L_HOLD;
        end
      end
      S_NIB_HOLD: begin
        if (cnt_zero) begin
          if (!init_done_q) begin
            state_d = S_INIT_WAIT;
            cnt_d   = (step_q == 2'd0) ? L_INIT1 :
                      (step_q == 2'd3) ? L_CMD : L_INIT2;
          end else if (!low_q) begin
            state_d = S_GAP;
            cnt_d   = L_GAP;
          end else begin
            state_d = S_BUSY;
            cnt_d   = clr_q ? L_CLEAR : L_CMD;
          end
        end
      end
      S_INIT_WAIT: begin
        if (cnt_zero) begin
          if (step_q == 2'd3) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
            rs_d        = 1'b0;
            nib_d       = 4'h0;
          end else begin
            state_d = S_NIB_SETUP;
            cnt_d   = L_SETUP;
            step_d  = step_q + 2'd1;
            nib_d   = (step_q == 2'd2) ? 4'h2 : 4'h3;
          end
        end
      end
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_NIB_SETUP;
          cnt_d   = L_SETUP;
          low_d   = 1'b0;
          rs_d    = req_rs;
          nib_d   = req_data[7:4];
          lo_d    = req_data[3:0];
          // Clear display / return home take much longer than other commands.
          clr_d   = !req_rs && (req_data == 8'h01 || req_data == 8'h02 || req_data == 8'h03);
        end
      end
      S_GAP: begin
        if (cnt_zero) begin
          state_d = S_NIB_SETUP;
          cnt_d   = L_SETUP;
          low_d   = 1'b1;
          nib_d   = lo_q;
        end
      end
      S_BUSY: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
          rs_d    = 1'b0;
          nib_d   = 4'h0;
        end
      end
      default: begin
        state_d = S_PWR_WAIT;
      end
    endcase

    // Registered strobe follows the pulse state exactly, without decode glitches.
    e_d = (state_d == S_NIB_HIGH);
  end

  assign req_ready    = (state_q == S_IDLE);
  assign init_done    = init_done_q;
  assign sf_e         = 1'b1;
  assign rw           = 1'b0;
  assign e            = e_q;
  assign rs           = rs_q;
  assign {d, c, b, a} = nib_q;
  assign dbg_state    = state_q;

endmodule
